time_set_entry: RTL and testbench
=================================

Name: time_set_entry

Overview:
Button-driven time/alarm entry controller: the writer side of the counters' set interface (set0/set1 digits, ishour, EN_setalarm).
- Turns three debounced push-buttons into validated BCD hour (00-23) and minute (00-59) digits.
- Drives an edit-active level, a field select and a one-cycle commit strobe; MOD_24 / MOD_60 counters load from these outputs.
- Sits between the button debouncers and the counter/alarm register bank.

Parameters:
TIMEOUT_CYCLES, 32'd600000, idle cycles in an edit state before abandoning edit (no commit)
BLINK_CYCLES, 32'd25000, half-period of blink output while editing
REPEAT_DELAY, 32'd50000, hold cycles before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_RATE, 32'd10000, cycles between auto-repeat steps (AUTO_REPEAT_EN only)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
btn_mode  input  1  debounced, synchronised level; enter edit / next field / commit
btn_inc  input  1  debounced level; increment selected field
btn_dec  input  1  debounced level; decrement selected field
cur_hr_ones, cur_hr_tens  input  4 each  current BCD hour, captured on edit entry
cur_min_ones, cur_min_tens  input  4 each  current BCD minute, captured on edit entry
set_hr_ones, set_hr_tens, set_min_ones, set_min_tens  output  4 each  edited BCD value
edit_active  output  1  high in EDIT_HOUR/EDIT_MIN
ishour  output  1  1 = hour field selected (valid while edit_active)
commit  output  1  one-cycle strobe: set_* valid, load now
blink  output  1  toggles every BLINK_CYCLES while editing, 0 otherwise

Behaviour:
- Reset (RST=1 at a rising CLK): state IDLE; all set_* = 0; edit_active, ishour, commit, blink = 0; timeout/blink/repeat counters = 0.
- Reset also sets the previous-sample registers of the buttons to 1, so a button held through reset is not a press.
- RST mid-edit: abandons the edit immediately with no commit.
- Press = button sampled 1 at this edge and 0 at the previous edge. Its effect is visible in registered outputs after that same edge (1-cycle latency).
- Priority in one cycle: mode press > inc/dec. Simultaneous inc and dec presses: neither applied; the timeout is still restarted.
- FSM states and transitions:
  - IDLE: on mode press, capture cur_* into set_* and go to EDIT_HOUR (edit_active=1, ishour=1).
    - Captured hour is invalid (tens>2, ones>9, or tens=2 and ones>3): load 00.
    - Captured minute is invalid (tens>5 or ones>9): load 00.
  - EDIT_HOUR: inc/dec step the hour; mode press goes to EDIT_MIN (ishour=0).
  - EDIT_MIN: inc/dec step the minute; mode press goes to COMMIT.
  - COMMIT: commit=1 and edit_active=0 for exactly one cycle, then IDLE. set_* hold the final values from COMMIT onward.
  - Timeout: in either EDIT state, TIMEOUT_CYCLES consecutive cycles without any press return the FSM to IDLE. commit stays 0 and set_* keep their values.
- BCD arithmetic:
  - Always BCD, never binary; carries ripple ones to tens.
  - Hour: inc 09->10, 19->20, 23->00; dec 00->23, 10->09.
  - Minute: inc 09->10, 59->00; dec 00->59, 50->49.
- Timeout counter and blink counter clear on entry to any EDIT state. Timeout counter also clears on every press.
- blink is forced to 0 on leaving the EDIT states.

Optional Feature:
Macro TIME_SET_AUTO_REPEAT_EN.
- Defined: while btn_inc (or btn_dec) stays high and alone in an EDIT state, one step is applied REPEAT_DELAY cycles after the press, then one step every REPEAT_RATE cycles.
  - Each repeat step restarts the timeout.
  - Releasing the button, pressing the other step button, or changing field stops the repeat.
- Undefined: only the edge-press step exists; the repeat counter and its parameters are unused and no logic is generated for them.

Test Plan:
- Reset with btn_mode held high, then release and re-press -> no state change during hold; the re-press enters EDIT_HOUR, edit_active=1, ishour=1.
- cur=23:59, mode press, then inc press -> set_hr=00, set_min=59. Then mode, inc -> set_min=00. Then mode -> commit high exactly 1 cycle, outputs 00:00.
- cur=2:7 hour (tens=2, ones=7, invalid) and 6:1 minute (invalid), mode press -> set_hr=00, set_min=00. Then dec in EDIT_HOUR -> 23.
- In EDIT_HOUR press inc and dec in the same cycle -> value unchanged; mode and inc in the same cycle -> field advances, hour unchanged.
- Enter edit, no presses for TIMEOUT_CYCLES (set 100 in bench) -> IDLE at cycle 100, commit never asserted, blink=0.
- With TIME_SET_AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5: hold inc from minute 57 -> 58 at the press, 59 at +20, 00 at +25, 01 at +30. Release -> no further steps.

Source files
------------

// File: rtl/time_set_entry_if.sv
// Button/current-time inputs and edited-time outputs of the time entry controller.
// Latency: none (signal bundle only). Backpressure: none, level signals.
interface time_set_entry_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [3:0] cur_hr_ones;
    logic [3:0] cur_hr_tens;
    logic [3:0] cur_min_ones;
    logic [3:0] cur_min_tens;
    logic [3:0] set_hr_ones;
    logic [3:0] set_hr_tens;
    logic [3:0] set_min_ones;
    logic [3:0] set_min_tens;
    logic       edit_active;
    logic       ishour;
    logic       commit;
    logic       blink;

    modport master (
        input  btn_mode, btn_inc, btn_dec,
        input  cur_hr_ones, cur_hr_tens, cur_min_ones, cur_min_tens,
        output set_hr_ones, set_hr_tens, set_min_ones, set_min_tens,
        output edit_active, ishour, commit, blink
    );

    modport slave (
        output btn_mode, btn_inc, btn_dec,
        output cur_hr_ones, cur_hr_tens, cur_min_ones, cur_min_tens,
        input  set_hr_ones, set_hr_tens, set_min_ones, set_min_tens,
        input  edit_active, ishour, commit, blink
    );
endinterface

// File: rtl/time_set_entry.sv
// Button-driven BCD hour/minute entry FSM; auto-repeat under TIME_SET_AUTO_REPEAT_EN.
// Latency: a press acts on registered outputs after the edge that samples it.
// Backpressure: none; buttons are levels, commit is a one-cycle strobe.
module time_set_entry #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd600000,
    parameter logic [31:0] BLINK_CYCLES   = 32'd25000,
    parameter logic [31:0] REPEAT_DELAY   = 32'd50000,
    parameter logic [31:0] REPEAT_RATE    = 32'd10000
) (
    input  logic             CLK,
    input  logic             RST,
    time_set_entry_if.master bus
);
    typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  hr_q, hr_d, min_q, min_d;
    logic        mode_q, inc_q, dec_q;
    logic [31:0] to_cnt_q, blink_cnt_q;
    logic        blink_q;
    logic        mode_p, inc_p, dec_p;
    logic        rep_up_fire, rep_dn_fire, rep_fire;
    logic        step_up, step_dn, restart, timeout, enter_edit, edit_d;
    logic        hr_ok, min_ok;

    // BCD step with wrap: up from max gives 00, down from 00 gives max.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] max);
        logic [7:0] r;
        if (up) begin
            if (v == max)               r = 8'h00;
            else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
            else                        r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == 8'h00)             r = max;
            else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
            else                        r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign mode_p = bus.btn_mode & ~mode_q;
    assign inc_p  = bus.btn_inc  & ~inc_q;
    assign dec_p  = bus.btn_dec  & ~dec_q;

    assign hr_ok  = ((bus.cur_hr_tens < 4'd2) && (bus.cur_hr_ones <= 4'd9)) ||
                    ((bus.cur_hr_tens == 4'd2) && (bus.cur_hr_ones <= 4'd3));
    assign min_ok = (bus.cur_min_tens <= 4'd5) && (bus.cur_min_ones <= 4'd9);

    assign rep_fire = rep_up_fire | rep_dn_fire;
    assign step_up  = (inc_p & ~dec_p) | rep_up_fire;
    assign step_dn  = (dec_p & ~inc_p) | rep_dn_fire;
    assign restart  = mode_p | inc_p | dec_p | rep_fire;
    assign timeout  = ~restart && (to_cnt_q == TIMEOUT_CYCLES - 32'd1);
    assign edit_d   = (state_d == EDIT_HOUR) || (state_d == EDIT_MIN);

    always_comb begin
        state_d    = state_q;
        hr_d       = hr_q;
        min_d      = min_q;
        enter_edit = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode_p) begin
                    state_d    = EDIT_HOUR;
                    enter_edit = 1'b1;
                    hr_d       = hr_ok  ? {bus.cur_hr_tens,  bus.cur_hr_ones}  : 8'h00;
                    min_d      = min_ok ? {bus.cur_min_tens, bus.cur_min_ones} : 8'h00;
                end
            end
            EDIT_HOUR: begin
                if (mode_p) begin
                    state_d    = EDIT_MIN;
                    enter_edit = 1'b1;
                end else if (step_up || step_dn) begin
                    hr_d = bcd_step(hr_q, step_up, 8'h23);
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            EDIT_MIN: begin
                if (mode_p) begin
                    state_d = COMMIT;
                end else if (step_up || step_dn) begin
                    min_d = bcd_step(min_q, step_up, 8'h59);
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            hr_q        <= 8'h00;
            min_q       <= 8'h00;
            mode_q      <= 1'b1;
            inc_q       <= 1'b1;
            dec_q       <= 1'b1;
            to_cnt_q    <= 32'd0;
            blink_cnt_q <= 32'd0;
            blink_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            mode_q  <= bus.btn_mode;
            inc_q   <= bus.btn_inc;
            dec_q   <= bus.btn_dec;
            if (!edit_d || enter_edit || restart) to_cnt_q <= 32'd0;
            else                                  to_cnt_q <= to_cnt_q + 32'd1;
            if (!edit_d) begin
                blink_cnt_q <= 32'd0;
                blink_q     <= 1'b0;
            end else if (enter_edit) begin
                blink_cnt_q <= 32'd0;
            end else if (blink_cnt_q == BLINK_CYCLES - 32'd1) begin
                blink_cnt_q <= 32'd0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 32'd1;
            end
        end
    end

`ifdef TIME_SET_AUTO_REPEAT_EN
    logic        rep_on_q, rep_up_q, rep_first_q;
    logic [31:0] rep_cnt_q;
    logic        held_alone, rep_due;

    // Repeat only continues while the arming button stays high and the other stays low.
    assign held_alone = rep_up_q ? (bus.btn_inc & ~bus.btn_dec) : (bus.btn_dec & ~bus.btn_inc);
    assign rep_due    = rep_cnt_q == ((rep_first_q ? REPEAT_DELAY : REPEAT_RATE) - 32'd1);
    assign rep_up_fire = rep_on_q & held_alone & rep_due & ~(mode_p | inc_p | dec_p) &
                         rep_up_q & ((state_q == EDIT_HOUR) || (state_q == EDIT_MIN));
    assign rep_dn_fire = rep_on_q & held_alone & rep_due & ~(mode_p | inc_p | dec_p) &
                         ~rep_up_q & ((state_q == EDIT_HOUR) || (state_q == EDIT_MIN));

    always_ff @(posedge CLK) begin
        if (RST) begin
            rep_on_q    <= 1'b0;
            rep_up_q    <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= 32'd0;
        end else if (!edit_d || mode_p || (inc_p && dec_p)) begin
            rep_on_q  <= 1'b0;
            rep_cnt_q <= 32'd0;
        end else if (inc_p || dec_p) begin
            rep_on_q    <= 1'b1;
            rep_up_q    <= inc_p;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= 32'd0;
        end else if (!held_alone) begin
            rep_on_q  <= 1'b0;
            rep_cnt_q <= 32'd0;
        end else if (rep_fire) begin
            rep_first_q <= 1'b0;
            rep_cnt_q   <= 32'd0;
        end else if (rep_on_q) begin
            rep_cnt_q <= rep_cnt_q + 32'd1;
        end
    end
`else
    localparam logic unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rep_up_fire = 1'b0;
    assign rep_dn_fire = 1'b0;
`endif

    assign bus.set_hr_tens  = hr_q[7:4];
    assign bus.set_hr_ones  = hr_q[3:0];
    assign bus.set_min_tens = min_q[7:4];
    assign bus.set_min_ones = min_q[3:0];
    assign bus.edit_active  = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);
    assign bus.ishour       = state_q == EDIT_HOUR;
    assign bus.commit       = state_q == COMMIT;
    assign bus.blink        = blink_q;
endmodule

// File: tb/tb_time_set_entry.sv
// Directed bench for time_set_entry; the hold-to-repeat section follows TIME_SET_AUTO_REPEAT_EN.
module tb_time_set_entry;
    logic CLK;
    logic RST;
    int   total;
    int   bad;
    int   commits;
    logic [7:0] hr_obs, min_obs;

    time_set_entry_if bus();

    time_set_entry #(
        .TIMEOUT_CYCLES(32'd100),
        .BLINK_CYCLES  (32'd4),
        .REPEAT_DELAY  (32'd20),
        .REPEAT_RATE   (32'd5)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    assign hr_obs  = {bus.set_hr_tens,  bus.set_hr_ones};
    assign min_obs = {bus.set_min_tens, bus.set_min_ones};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m);
        {bus.cur_hr_tens, bus.cur_hr_ones}   = h;
        {bus.cur_min_tens, bus.cur_min_ones} = m;
    endtask

    // One-cycle press followed by a release cycle; checks belong after the press edge.
    task automatic press_mode();
        bus.btn_mode = 1'b1; tick(); bus.btn_mode = 1'b0; tick();
    endtask

    initial begin
        total = 0; bad = 0; commits = 0;
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
        set_cur(8'h12, 8'h34);
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        chk("reset_flags", {bus.edit_active, bus.ishour, bus.commit, bus.blink}, 4'b0000);
        chk("reset_hr", hr_obs, 8'h00);
        chk("reset_min", min_obs, 8'h00);

        // mode held through reset is not a press
        repeat (3) tick();
        chk("held_mode_no_edit", bus.edit_active, 1'b0);
        bus.btn_mode = 1'b0; tick();
        chk("release_no_edit", bus.edit_active, 1'b0);
        bus.btn_mode = 1'b1; tick();
        chk("repress_edit_hour", {bus.edit_active, bus.ishour}, 2'b11);
        chk("capture_hr", hr_obs, 8'h12);
        chk("capture_min", min_obs, 8'h34);
        bus.btn_mode = 1'b0; tick();
        tick(); tick();
        chk("blink_low_before", bus.blink, 1'b0);
        tick();
        chk("blink_toggle", bus.blink, 1'b1);

        // reset mid-edit drops the edit without commit
        RST = 1'b1; tick(); RST = 1'b0;
        chk("rst_mid_edit", {bus.edit_active, bus.commit, bus.blink}, 3'b000);
        tick();

        // 23:59 -> inc hour -> 00, inc minute -> 00, commit
        set_cur(8'h23, 8'h59);
        bus.btn_mode = 1'b1; tick();
        chk("cap_2359", {hr_obs, min_obs}, 16'h2359);
        bus.btn_mode = 1'b0; tick();
        bus.btn_inc = 1'b1; tick();
        chk("hr_inc_wrap", {hr_obs, min_obs}, 16'h0059);
        bus.btn_inc = 1'b0; tick();
        press_mode();
        chk("edit_min_sel", {bus.edit_active, bus.ishour}, 2'b10);
        bus.btn_inc = 1'b1; tick();
        chk("min_inc_wrap", {hr_obs, min_obs}, 16'h0000);
        bus.btn_inc = 1'b0; tick();
        bus.btn_mode = 1'b1; tick();
        chk("commit_pulse", {bus.commit, bus.edit_active}, 2'b10);
        chk("commit_val", {hr_obs, min_obs}, 16'h0000);
        bus.btn_mode = 1'b0; tick();
        chk("commit_one_cycle", {bus.commit, bus.edit_active}, 2'b00);

        // invalid capture loads 00:00; dec hour wraps to 23
        set_cur(8'h27, 8'h61);
        bus.btn_mode = 1'b1; tick();
        chk("invalid_capture", {hr_obs, min_obs}, 16'h0000);
        bus.btn_mode = 1'b0; tick();
        bus.btn_dec = 1'b1; tick();
        chk("hr_dec_wrap", hr_obs, 8'h23);
        bus.btn_dec = 1'b0; tick();
        bus.btn_inc = 1'b1; bus.btn_dec = 1'b1; tick();
        chk("inc_dec_same_cycle", hr_obs, 8'h23);
        bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; tick();
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b1; tick();
        chk("mode_beats_inc_sel", {bus.edit_active, bus.ishour}, 2'b10);
        chk("mode_beats_inc_hr", hr_obs, 8'h23);
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; tick();
        bus.btn_dec = 1'b1; tick();
        chk("min_dec_wrap", min_obs, 8'h59);
        bus.btn_dec = 1'b0; tick();
        press_mode();

        // tens borrow/carry: 09 -> 10 -> 09 hour, 50 -> 49 minute, then timeout
        set_cur(8'h09, 8'h50);
        press_mode();
        bus.btn_inc = 1'b1; tick();
        chk("hr_09_to_10", hr_obs, 8'h10);
        bus.btn_inc = 1'b0; tick();
        bus.btn_dec = 1'b1; tick();
        chk("hr_10_to_09", hr_obs, 8'h09);
        bus.btn_dec = 1'b0; tick();
        press_mode();
        bus.btn_dec = 1'b1; tick();
        chk("min_50_to_49", min_obs, 8'h49);
        bus.btn_dec = 1'b0; tick();
        for (int i = 0; i < 98; i++) begin
            tick();
            if (bus.commit) commits++;
        end
        chk("edit_before_timeout", bus.edit_active, 1'b1);
        tick();
        if (bus.commit) commits++;
        chk("timeout_idle", {bus.edit_active, bus.blink, bus.commit}, 3'b000);
        chk("timeout_no_commit", commits, 0);
        chk("timeout_keeps_val", {hr_obs, min_obs}, 16'h0949);

        // holding inc in EDIT_MIN from 57
        set_cur(8'h12, 8'h57);
        press_mode();
        press_mode();
        bus.btn_inc = 1'b1; tick();
        chk("hold_press_step", min_obs, 8'h58);
`ifdef TIME_SET_AUTO_REPEAT_EN
        repeat (19) tick();
        chk("rep_before_delay", min_obs, 8'h58);
        tick();
        chk("rep_at_delay", min_obs, 8'h59);
        repeat (4) tick();
        chk("rep_before_rate", min_obs, 8'h59);
        tick();
        chk("rep_wrap", {hr_obs, min_obs}, 16'h1200);
        repeat (5) tick();
        chk("rep_second_rate", min_obs, 8'h01);
        bus.btn_inc = 1'b0;
        repeat (20) tick();
        chk("rep_stop_release", min_obs, 8'h01);
`else
        repeat (30) tick();
        chk("hold_no_repeat", min_obs, 8'h58);
        bus.btn_inc = 1'b0; tick();
`endif
        chk("hold_still_editing", bus.edit_active, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
